// File: rtl/unit_arbiter_pkg.sv
// rtl/unit_arbiter_pkg.sv - shared types for the unit bus arbiter
package unit_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    UNIT_SEL_NONE = 2'd0,
    UNIT_SEL_ALU  = 2'd1,
    UNIT_SEL_MUL  = 2'd2,
    UNIT_SEL_MEM  = 2'd3
  } unit_sel_t;

  // Advance a thread index by one with wrap to zero.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/unit_arbiter_rr_pick.sv
// rtl/unit_arbiter_rr_pick.sv - rotated priority scan, one-hot grant
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          found;

  // First requester at or above start_i, wrapping past the top index.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, start_i} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      idx = sum[IW-1:0];
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unit_arbiter.sv
// rtl/unit_arbiter.sv - zero-latency round-robin arbiter with bounded lock
module unit_arbiter
  import unit_arbiter_pkg::*;
#(
  parameter int N_THREADS = 4,
  parameter int LOCK_MAX  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_THREADS-1:0] t_req,
  input  logic [N_THREADS-1:0] t_lock,
  input  unit_sel_t            t_sel  [N_THREADS],
  input  word_t                t_ctrl [N_THREADS],
  input  word_t                t_in   [N_THREADS][2],
  output logic [N_THREADS-1:0] t_gnt,
  output word_t                t_out,
  output unit_sel_t            unit_sel,
  output word_t                unit_ctrl,
  output word_t                unit_in [2],
  input  word_t                unit_out
);

  localparam int IW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic                 owner_vld_q, owner_vld_d;
  logic [CW-1:0]        lock_cnt_q, lock_cnt_d;
  // Set for the one cycle after a forced release so the former owner
  // cannot immediately grab the lock back.
  logic                 rls_q, rls_d;

  logic [N_THREADS-1:0] rr_gnt, gnt;
  logic [IW-1:0]        gnt_idx;
  logic [CW-1:0]        lock_base;
  logic                 owner_hold, gnt_any, lock_ok;

  rr_pick #(
    .N  (N_THREADS),
    .IW (IW)
  ) u_rr_pick (
    .req_i   (t_req),
    .start_i (ptr_q),
    .gnt_o   (rr_gnt)
  );

  // Lock holder wins while it keeps requesting; otherwise round-robin.
  always_comb begin
    owner_hold = owner_vld_q && t_req[owner_q];
    gnt        = '0;
    if (!rst) begin
      if (owner_hold) begin
        gnt[owner_q] = 1'b1;
      end else begin
        gnt = rr_gnt;
      end
    end
    gnt_any = |gnt;
    gnt_idx = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      if (gnt[i]) begin
        gnt_idx = IW'(i);
      end
    end
  end

  // Forward the granted thread's request to the shared units.
  always_comb begin
    unit_sel   = UNIT_SEL_NONE;
    unit_ctrl  = '0;
    unit_in[0] = '0;
    unit_in[1] = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      if (gnt[i]) begin
        unit_sel   = t_sel[i];
        unit_ctrl  = t_ctrl[i];
        unit_in[0] = t_in[i][0];
        unit_in[1] = t_in[i][1];
      end
    end
  end

  assign t_gnt = gnt;
  assign t_out = unit_out;

  // Pointer and lock bookkeeping for the next cycle.
  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    lock_cnt_d  = lock_cnt_q;
    rls_d       = 1'b0;
    lock_base   = owner_hold ? lock_cnt_q : '0;
    lock_ok     = t_lock[gnt_idx] && !(rls_q && (gnt_idx == owner_q));
    if (!gnt_any) begin
      owner_vld_d = 1'b0;
      lock_cnt_d  = '0;
    end else begin
      if (!owner_hold) begin
        ptr_d = IW'(wrap_inc(int'(gnt_idx), N_THREADS));
      end
      if (lock_ok) begin
        owner_d = gnt_idx;
        if (int'(lock_base) + 1 >= LOCK_MAX) begin
          // Lock budget spent: release and put the owner last in line.
          owner_vld_d = 1'b0;
          lock_cnt_d  = '0;
          ptr_d       = IW'(wrap_inc(int'(gnt_idx), N_THREADS));
          rls_d       = 1'b1;
        end else begin
          owner_vld_d = 1'b1;
          lock_cnt_d  = lock_base + CW'(1);
        end
      end else begin
        owner_vld_d = 1'b0;
        lock_cnt_d  = '0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      lock_cnt_q  <= '0;
      rls_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      lock_cnt_q  <= lock_cnt_d;
      rls_q       <= rls_d;
    end
  end

endmodule

// File: tb/tb_unit_arbiter.sv
// tb/tb_unit_arbiter.sv - scoreboard bench for unit_arbiter
module tb_unit_arbiter;
  import unit_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  t_req;
  logic [3:0]  t_lock;
  unit_sel_t   t_sel  [4];
  word_t       t_ctrl [4];
  word_t       t_in   [4][2];
  logic [3:0]  t_gnt;
  word_t       t_out;
  unit_sel_t   unit_sel;
  word_t       unit_ctrl;
  word_t       unit_in [2];
  word_t       unit_out;

  typedef struct {
    string     name;
    logic [3:0] gnt;
    unit_sel_t sel;
    word_t     ctrl;
    word_t     in0;
    word_t     in1;
    word_t     tout;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;
  int   n_issued;

  unit_arbiter #(
    .N_THREADS (4),
    .LOCK_MAX  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .t_req     (t_req),
    .t_lock    (t_lock),
    .t_sel     (t_sel),
    .t_ctrl    (t_ctrl),
    .t_in      (t_in),
    .t_gnt     (t_gnt),
    .t_out     (t_out),
    .unit_sel  (unit_sel),
    .unit_ctrl (unit_ctrl),
    .unit_in   (unit_in),
    .unit_out  (unit_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input string nm, input logic r, input logic [3:0] req,
                       input logic [3:0] lock, input logic [3:0] exp_gnt,
                       input logic mem2);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    t_req  = req;
    t_lock = lock;
    for (int i = 0; i < 4; i++) begin
      t_sel[i]   = unit_sel_t'(2'((i % 3) + 1));
      t_ctrl[i]  = word_t'(32'hC0 + i);
      t_in[i][0] = word_t'(32'h100 + i);
      t_in[i][1] = word_t'(32'h200 + i);
    end
    if (mem2) begin
      t_sel[2]   = UNIT_SEL_MEM;
      t_in[2][0] = 32'h10;
      unit_out   = 32'hDEAD;
    end else begin
      unit_out   = word_t'(32'hA000 + n_issued);
    end
    e.name = nm;
    e.gnt  = exp_gnt;
    e.sel  = UNIT_SEL_NONE;
    e.ctrl = '0;
    e.in0  = '0;
    e.in1  = '0;
    e.tout = unit_out;
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt[i]) begin
        e.sel  = t_sel[i];
        e.ctrl = t_ctrl[i];
        e.in0  = t_in[i][0];
        e.in1  = t_in[i][1];
      end
    end
    if (mem2) begin
      e.in0  = 32'h10;
      e.tout = 32'hDEAD;
    end
    n_issued++;
    sb_q.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle the DUT presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (t_gnt !== e.gnt || unit_sel !== e.sel || unit_ctrl !== e.ctrl ||
            unit_in[0] !== e.in0 || unit_in[1] !== e.in1 || t_out !== e.tout) begin
          n_err++;
          $display("FAIL %s: got gnt=%b sel=%0d ctrl=%h in=%h/%h out=%h, want gnt=%b sel=%0d ctrl=%h in=%h/%h out=%h",
                   e.name, t_gnt, unit_sel, unit_ctrl, unit_in[0], unit_in[1], t_out,
                   e.gnt, e.sel, e.ctrl, e.in0, e.in1, e.tout);
        end
      end
    end
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    n_issued = 0;
    rst      = 1'b1;
    t_req    = '0;
    t_lock   = '0;
    unit_out = '0;
    for (int i = 0; i < 4; i++) begin
      t_sel[i]   = UNIT_SEL_NONE;
      t_ctrl[i]  = '0;
      t_in[i][0] = '0;
      t_in[i][1] = '0;
    end

    apply("reset", 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0);

    // Round-robin from reset, pointer wraps back to 0.
    apply("rr_0",    1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0);
    apply("rr_1",    1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b0);
    apply("rr_2",    1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b0);
    apply("rr_3",    1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b0);
    apply("rr_wrap", 1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0);

    // Idle cycles leave the pointer at 1.
    for (int k = 0; k < 3; k++) begin
      apply($sformatf("idle_%0d", k), 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    apply("idle_ptr", 1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b0);

    // Single requester, same-cycle forwarding.
    apply("mem2", 1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1);

    // Bounded lock on thread 1.
    apply("pre_lock", 1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      apply($sformatf("lock1_%0d", k), 1'b0, 4'b1111, 4'b0010, 4'b0010, 1'b0);
    end
    apply("post_lock_2", 1'b0, 4'b1111, 4'b0010, 4'b0100, 1'b0);
    apply("post_lock_3", 1'b0, 4'b1111, 4'b0010, 4'b1000, 1'b0);
    apply("post_lock_0", 1'b0, 4'b1111, 4'b0010, 4'b0001, 1'b0);
    apply("relock_1",    1'b0, 4'b1111, 4'b0010, 4'b0010, 1'b0);

    // Owner drops its request mid-lock.
    apply("drop_rr",   1'b0, 4'b1101, 4'b0000, 4'b0100, 1'b0);
    apply("drop_free", 1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b0);

    // Forced release, former owner cannot re-lock immediately.
    for (int k = 1; k <= 8; k++) begin
      apply($sformatf("solo_lock_%0d", k), 1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b0);
    end
    apply("blocked_relock", 1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b0);
    apply("not_relocked",   1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b0);

    // Reset during a lock held by thread 3.
    apply("lock3_a",   1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b0);
    apply("lock3_b",   1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b0);
    apply("rst_mid",   1'b1, 4'b1111, 4'b1000, 4'b0000, 1'b0);
    apply("after_rst", 1'b0, 4'b1001, 4'b0000, 4'b0001, 1'b0);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
      @(negedge clk);
    end
    #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
